muldiv_seq: RTL and testbench

Sequential signed multiply/divide engine and its controller, sitting between registers A/B and the HI/LO registers of the multicycle MIPS datapath. On a one-cycle `start` from the control unit it runs a 32-iteration shift-add multiply (MULT) or restoring divide (DIV) and presents results for HI and LO. Completion is signalled with a one-cycle `done` pulse, which the control unit uses as HiCtrl/LoCtrl write enable. Division by zero is detected up front and reported without iterating.

---
 rtl/muldiv_seq.sv | 134 +++++++++++++
 tb/tb_muldiv_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential signed multiply/divide engine for the HI/LO registers
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    logic [1:0]         state;
    logic [5:0]         iter_cnt;
    logic               op_q;
    logic               neg_lo;
    logic               neg_hi;
    logic               dz_q;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    // MULT: {partial product, remaining multiplier bits}; DIV: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mult_sum;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_signed;

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign div_zero = (state == DONE) && dz_q;

    // Operand magnitudes; the most negative value maps to its unsigned magnitude
    always_comb begin
        a_abs = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
        b_abs = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
        div_trial = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {2'b00, b_mag};
        acc_step  = '0;
        if (!op_q) begin
            acc_step = {mult_sum, acc[WIDTH-1:1]};
        end else if (!div_trial[WIDTH+1]) begin
            acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {acc[2*WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction of the unsigned results
    always_comb begin
        prod_signed = neg_lo ? (~acc + 1'b1) : acc;
        quo_signed  = neg_lo ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_signed  = neg_hi ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    // Controller and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            iter_cnt <= '0;
            op_q     <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            dz_q     <= 1'b0;
            a_mag    <= '0;
            b_mag    <= '0;
            acc      <= '0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    dz_q <= 1'b0;
                    if (start) begin
                        if (op && (b_in == '0)) begin
                            dz_q  <= 1'b1;
                            state <= DONE;
                        end else begin
                            op_q     <= op;
                            a_mag    <= a_abs;
                            b_mag    <= b_abs;
                            neg_lo   <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                            neg_hi   <= op ? a_in[WIDTH-1] : (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                            acc      <= {{WIDTH{1'b0}}, (op ? a_abs : b_abs)};
                            iter_cnt <= '0;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc      <= acc_step;
                    iter_cnt <= iter_cnt + 6'd1;
                    if (iter_cnt == LAST_ITER) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    if (!op_q) begin
                        hi_out <= prod_signed[2*WIDTH-1:WIDTH];
                        lo_out <= prod_signed[WIDTH-1:0];
                    end else begin
                        hi_out <= rem_signed;
                        lo_out <= quo_signed;
                    end
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq with a behavioural reference model
module tb_muldiv_seq;

    localparam int WIDTH = 32;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    typedef struct {
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          vectors;
    int          miscompares;
    int          cycle;
    int          done_cycle;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    muldiv_seq #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a),
        .b_in     (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed 64-bit arithmetic; SV division truncates toward zero, % follows dividend
    function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] prev_hi, input logic [31:0] prev_lo);
        exp_t   e;
        longint sx;
        longint sy;
        longint p;
        longint q;
        longint r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.dz = 1'b0;
        if (!o) begin
            p    = sx * sy;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (y == 32'd0) begin
            e.dz = 1'b1;
            e.hi = prev_hi;
            e.lo = prev_lo;
        end else begin
            q    = sx / sy;
            r    = sx % sy;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest queued expectation
    always @(negedge clock) begin
        if (!reset) begin
            if (div_zero && !done) check("div_zero_without_done", 64'(div_zero), 64'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("div_zero", 64'(div_zero), 64'(e.dz));
                    check("hi_out", 64'(hi_out), 64'(e.hi));
                    check("lo_out", 64'(lo_out), 64'(e.lo));
                end
            end
        end
    end

    // Issue one operation, then check latency and busy duration; pulse_at injects an ignored start
    task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y, input int pulse_at);
        exp_t e;
        int   lat;
        int   cnt;
        int   busy_cnt;
        @(negedge clock);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        e = model(o, x, y, last_hi, last_lo);
        sb.push_back(e);
        last_hi = e.hi;
        last_lo = e.lo;
        lat = (o && y == 32'd0) ? 1 : WIDTH + 2;
        cnt = 0;
        busy_cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
            if (cnt == pulse_at) begin
                start = 1'b1;
                op    = 1'b1;
                a     = 32'd9;
                b     = 32'd3;
            end else begin
                start = 1'b0;
                op    = 1'($urandom);
                a     = $urandom;
                b     = $urandom;
            end
            if (busy) busy_cnt++;
        end while (!done && cnt < 100);
        check("latency", 64'(cnt), 64'(lat));
        check("busy_cycles", 64'(busy_cnt), 64'(lat));
        done_cycle = cycle;
    endtask

    initial begin
        int first_done;
        int done_seen;
        vectors     = 0;
        miscompares = 0;
        cycle       = 0;
        last_hi     = '0;
        last_lo     = '0;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clock);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_div_zero", 64'(div_zero), 64'd0);
        check("reset_hi", 64'(hi_out), 64'd0);
        check("reset_lo", 64'(lo_out), 64'd0);
        reset = 1'b0;

        do_op(1'b0, 32'd7, 32'hFFFFFFFD, 0);
        check("mult_7_m3_hi", 64'(hi_out), 64'hFFFFFFFF);
        check("mult_7_m3_lo", 64'(lo_out), 64'hFFFFFFEB);
        do_op(1'b0, 32'h80000000, 32'h80000000, 0);
        check("mult_min_min_hi", 64'(hi_out), 64'h40000000);
        do_op(1'b1, 32'hFFFFFFF9, 32'd2, 0);
        check("div_m7_2_lo", 64'(lo_out), 64'hFFFFFFFD);
        check("div_m7_2_hi", 64'(hi_out), 64'hFFFFFFFF);
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
        check("div_min_m1_lo", 64'(lo_out), 64'h80000000);
        do_op(1'b1, 32'd5, 32'd0, 0);
        check("div_zero_hold_lo", 64'(lo_out), 64'h80000000);
        @(negedge clock);
        check("div_zero_busy_after", 64'(busy), 64'd0);

        // Back-to-back issue in the first IDLE cycle after DONE
        do_op(1'b0, 32'd2, 32'd3, 0);
        first_done = done_cycle;
        do_op(1'b0, 32'd5, 32'd5, 0);
        check("b2b_lo", 64'(lo_out), 64'd25);
        check("b2b_interval", 64'(done_cycle - first_done), 64'(WIDTH + 3));

        // Ignored start mid-run, then reset aborts a second MULT
        do_op(1'b0, 32'd3, 32'd4, 10);
        check("ignored_start_lo", 64'(lo_out), 64'd12);
        @(negedge clock);
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd6;
        b     = 32'd7;
        @(negedge clock);
        start = 1'b0;
        repeat (18) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        last_hi = '0;
        last_lo = '0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi_out), 64'd0);
        check("abort_lo", 64'(lo_out), 64'd0);
        done_seen = 0;
        repeat (60) begin
            @(negedge clock);
            if (done) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);

        // Randomized operations with occasional corner operands
        for (int i = 0; i < 40; i++) begin
            logic        o;
            logic [31:0] x;
            logic [31:0] y;
            o = 1'($urandom);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: x = 32'h80000000;
                2: y = 32'hFFFFFFFF;
                3: y = 32'($urandom_range(1, 9));
                default: ;
            endcase
            do_op(o, x, y, 0);
        end

        repeat (5) @(negedge clock);
        check("pending_results", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
